clk_tick_sched: RTL and testbench

CLK_TICK_SCHED -- requirements
Module: clk_tick_sched

---
 rtl/clk_tick_sched.sv | 175 +++++++++++++++++
 tb/tb_clk_tick_sched.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_tick_sched.sv
// clk_tick_sched: a prescaler produces a base tick every CLK_DIV clocks.
// On each base tick, a four-cycle scan updates the countdown of every
// active channel and emits a one-cycle o_tick pulse when a channel's
// period in base ticks has elapsed.
//
// Optional feature: define CLK_TICK_SCHED_LEVEL_EN to build per-channel
// toggle flops on o_level. These produce a 50%-duty square wave. Without
// the macro, o_level is tied to zero.
//
// Handshake: a configuration write is accepted in any cycle where both
// i_cfg_valid and o_cfg_ready are high. The requester holds the write
// fields stable while i_cfg_valid is high and ready is low. Ready is
// high only while the scheduler is idle, so a write can never interleave
// with a scan.
//
// o_dbg_state exposes {scanning, scan_index} so that checkers can follow
// the FSM.
module clk_tick_sched #(
    parameter int CLK_DIV = 63000,
    parameter int PW      = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cfg_valid,
    output logic          o_cfg_ready,
    input  logic [1:0]    i_cfg_ch,
    input  logic          i_cfg_en,
    input  logic [PW-1:0] i_cfg_period,
    output logic [3:0]    o_tick,
    output logic [3:0]    o_level,
    output logic          o_base_tick,
    output logic [2:0]    o_dbg_state
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] PRESC_LAST = DW'(CLK_DIV - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t        state_q, state_nxt;
    logic [1:0]    idx_q, idx_nxt;
    logic [DW-1:0] presc_q;

    logic          en_q     [4];
    logic [PW-1:0] period_q [4];
    logic [PW-1:0] cnt_q    [4];

    logic [3:0]    ch_active;
    logic [3:0]    tick_nxt;
    logic          cfg_acc;
    logic          scan_hit;

    // Prescaler: free-running 0..CLK_DIV-1 counter; the only place wrap arithmetic occurs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q <= '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + DW'(1);
        end
    end

    assign o_base_tick = (presc_q == PRESC_LAST);

    // FSM state register: scan state and scan index.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_nxt;
            idx_q   <= idx_nxt;
        end
    end

    // FSM next state: start a scan on each base tick, then walk channels 0..3.
    always_comb begin
        state_nxt   = state_q;
        idx_nxt     = idx_q;
        o_cfg_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_cfg_ready = 1'b1;
                if (o_base_tick) begin
                    state_nxt = ST_SCAN;
                    idx_nxt   = 2'd0;
                end
            end
            ST_SCAN: begin
                idx_nxt = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = 2'd0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = 2'd0;
            end
        endcase
    end

    assign o_dbg_state = {state_q == ST_SCAN, idx_q};
    assign cfg_acc     = i_cfg_valid && o_cfg_ready;

    // Channel activity and the tick decided in this scan cycle; a zero period means inactive.
    always_comb begin
        ch_active = '0;
        tick_nxt  = '0;
        for (int k = 0; k < 4; k++) begin
            ch_active[k] = en_q[k] && (period_q[k] != '0);
        end
        scan_hit = (state_q == ST_SCAN) && ch_active[idx_q];
        if (scan_hit && (cnt_q[idx_q] == PW'(1))) begin
            tick_nxt[idx_q] = 1'b1;
        end
    end

    // Channel registers: load on accepted write, count down or reload during scan.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < 4; k++) begin
                en_q[k]     <= 1'b0;
                period_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
            o_tick <= '0;
        end else begin
            o_tick <= tick_nxt;
            if (cfg_acc) begin
                en_q[i_cfg_ch]     <= i_cfg_en;
                period_q[i_cfg_ch] <= i_cfg_period;
                cnt_q[i_cfg_ch]    <= i_cfg_period;
            end
            if (scan_hit) begin
                if (cnt_q[idx_q] == PW'(1)) begin
                    cnt_q[idx_q] <= period_q[idx_q];
                end else if (cnt_q[idx_q] != '0) begin
                    cnt_q[idx_q] <= cnt_q[idx_q] - PW'(1);
                end
            end
        end
    end

`ifdef CLK_TICK_SCHED_LEVEL_EN
    logic [3:0] level_q;
    logic [3:0] level_clr;

    // A write with en=0 clears that channel's level; a write and a tick cannot coincide.
    always_comb begin
        level_clr = '0;
        if (cfg_acc && !i_cfg_en) begin
            level_clr[i_cfg_ch] = 1'b1;
        end
    end

    // Level flops toggle on the same edge that raises the channel's tick.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            level_q <= '0;
        end else begin
            level_q <= (level_q ^ tick_nxt) & ~level_clr;
        end
    end

    assign o_level = level_q;
`else
    assign o_level = 4'b0000;
`endif

endmodule

// File: tb/tb_clk_tick_sched.sv
// Testbench for clk_tick_sched with CLK_DIV = 10.
// The reference model works in base-tick terms. Each channel keeps a
// count of remaining base ticks. When that count reaches zero, a tick
// is scheduled at the base-tick cycle + 2 + channel.
module tb_clk_tick_sched;

    localparam int CLK_DIV = 10;
    localparam int PW      = 16;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_cfg_valid = 1'b0;
    logic          o_cfg_ready;
    logic [1:0]    i_cfg_ch = 2'd0;
    logic          i_cfg_en = 1'b0;
    logic [PW-1:0] i_cfg_period = '0;
    logic [3:0]    o_tick;
    logic [3:0]    o_level;
    logic          o_base_tick;
    logic [2:0]    o_dbg_state;

    // Clock
    always #5 i_clk = ~i_clk;

    clk_tick_sched #(.CLK_DIV(CLK_DIV), .PW(PW)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_cfg_valid  (i_cfg_valid),
        .o_cfg_ready  (o_cfg_ready),
        .i_cfg_ch     (i_cfg_ch),
        .i_cfg_en     (i_cfg_en),
        .i_cfg_period (i_cfg_period),
        .o_tick       (o_tick),
        .o_level      (o_level),
        .o_base_tick  (o_base_tick),
        .o_dbg_state  (o_dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_cyc;
    bit m_en   [4];
    int m_per  [4];
    int m_rem  [4];
    bit m_lvl  [4];
    int m_pend [4];
    bit m_ready;
    bit m_base;
    bit m_acc;

    function automatic logic [9:0] obs();
        return {o_base_tick, o_cfg_ready, o_tick, o_level};
    endfunction

    task automatic model_reset();
        m_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            m_en[k] = 1'b0; m_per[k] = 0; m_rem[k] = 0; m_lvl[k] = 1'b0; m_pend[k] = -1;
        end
        m_acc = 1'b0;
    endtask

    // Expected outputs for the current cycle, given the events already scheduled.
    task automatic model_expect(output logic [9:0] ev);
        logic [3:0] t;
        logic [3:0] l;
        m_base  = (m_cyc % CLK_DIV) == CLK_DIV - 1;
        m_ready = !(m_cyc >= CLK_DIV && (m_cyc % CLK_DIV) < 4);
        t = '0;
        for (int k = 0; k < 4; k++) begin
            if (m_pend[k] == m_cyc) begin
                t[k] = 1'b1;
                m_pend[k] = -1;
                m_lvl[k] = !m_lvl[k];
            end
        end
        for (int k = 0; k < 4; k++) l[k] = m_lvl[k];
`ifndef CLK_TICK_SCHED_LEVEL_EN
        l = '0;
`endif
        ev = {m_base, m_ready, t, l};
    endtask

    // Apply the clock edge that ends the current cycle: write first, then the base-tick bookkeeping.
    task automatic model_commit();
        int ch;
        ch = int'(i_cfg_ch);
        m_acc = i_cfg_valid && m_ready;
        if (m_acc) begin
            m_en[ch]  = i_cfg_en;
            m_per[ch] = int'(i_cfg_period);
            m_rem[ch] = int'(i_cfg_period);
            if (!i_cfg_en) m_lvl[ch] = 1'b0;
        end
        if (m_base) begin
            for (int k = 0; k < 4; k++) begin
                if (m_en[k] && m_per[k] != 0) begin
                    m_rem[k] = m_rem[k] - 1;
                    if (m_rem[k] == 0) begin
                        m_pend[k] = m_cyc + 2 + k;
                        m_rem[k]  = m_per[k];
                    end
                end
            end
        end
        m_cyc++;
    endtask

    task automatic step(output logic [9:0] ev);
        @(negedge i_clk);
        model_expect(ev);
    endtask

    task automatic set_cfg(input bit v, input int ch, input bit en, input int per);
        i_cfg_valid  = v;
        i_cfg_ch     = 2'(ch);
        i_cfg_en     = en;
        i_cfg_period = PW'(per);
    endtask

    // Hold reset for a few cycles, then release at a falling edge so the first sampled cycle is prescaler = 1.
    task automatic apply_reset();
        set_cfg(0, 0, 0, 0);
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
        m_cyc = 1;
    endtask

    task automatic test_reset();
        logic [9:0] ev;
        i_rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            set_cfg($urandom_range(0, 1), $urandom_range(0, 3), 1, $urandom_range(1, 5));
            checks++;
            if (obs() !== 10'b01_0000_0000 || o_dbg_state !== 3'd0) begin
                errors++;
                $display("FAIL reset_hold got=%b/%b exp=%b/%b", obs(), o_dbg_state, 10'b01_0000_0000, 3'd0);
            end
        end
        apply_reset();
        for (int c = 0; c < 35; c++) begin
            step(ev);
            checks++;
            if (obs() !== ev) begin
                errors++;
                $display("FAIL idle_run cyc=%0d got=%b exp=%b", m_cyc, obs(), ev);
            end
            model_commit();
        end
    endtask

    task automatic test_periods();
        logic [9:0] ev;
        apply_reset();
        for (int c = 0; c < 70; c++) begin
            step(ev);
            checks++;
            if (obs() !== ev) begin
                errors++;
                $display("FAIL periods cyc=%0d got=%b exp=%b", m_cyc, obs(), ev);
            end
            if (m_cyc == 1)      set_cfg(1, 0, 1, 1);
            else if (m_cyc == 2) set_cfg(1, 2, 1, 3);
            else                 set_cfg(0, 0, 0, 0);
            model_commit();
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] ev;
        int lowcnt;
        bit done;
        lowcnt = 0;
        done = 1'b0;
        apply_reset();
        for (int c = 0; c < 40; c++) begin
            step(ev);
            checks++;
            if (obs() !== ev) begin
                errors++;
                $display("FAIL hold_valid cyc=%0d got=%b exp=%b", m_cyc, obs(), ev);
            end
            if (!done && m_cyc >= CLK_DIV) begin
                if (o_cfg_ready === 1'b0) lowcnt++;
                set_cfg(1, 3, 1, 2);
            end else begin
                set_cfg(0, 0, 0, 0);
            end
            model_commit();
            if (m_acc) done = 1'b1;
        end
        checks++;
        if (lowcnt != 4 || !done) begin
            errors++;
            $display("FAIL ready_low_cycles got=%0d accepted=%0d exp=4 accepted=1", lowcnt, done);
        end
    endtask

    task automatic test_disable();
        logic [9:0] ev;
        int late_ticks;
        late_ticks = 0;
        apply_reset();
        for (int c = 0; c < 40; c++) begin
            step(ev);
            checks++;
            if (obs() !== ev) begin
                errors++;
                $display("FAIL disable cyc=%0d got=%b exp=%b", m_cyc, obs(), ev);
            end
            if (m_cyc > 19 && o_tick[1] === 1'b1) late_ticks++;
            if (m_cyc == 2)       set_cfg(1, 1, 1, 1);
            else if (m_cyc == 19) set_cfg(1, 1, 0, 1);
            else                  set_cfg(0, 0, 0, 0);
            model_commit();
        end
        checks++;
        if (late_ticks != 0 || o_level[1] !== 1'b0) begin
            errors++;
            $display("FAIL disable_final ticks=%0d level1=%b exp ticks=0 level1=0", late_ticks, o_level[1]);
        end
    endtask

    task automatic test_coincident_reset();
        logic [9:0] ev;
        apply_reset();
        while (m_cyc <= 12) begin
            step(ev);
            checks++;
            if (obs() !== ev) begin
                errors++;
                $display("FAIL coincident cyc=%0d got=%b exp=%b", m_cyc, obs(), ev);
            end
            if (m_cyc == 2)      set_cfg(1, 0, 1, 5);
            else if (m_cyc == 3) set_cfg(1, 2, 1, 1);
            else if (m_cyc == 9) set_cfg(1, 0, 1, 1);
            else                 set_cfg(0, 0, 0, 0);
            if (m_cyc == 12) break;
            model_commit();
        end
        set_cfg(0, 0, 0, 0);
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 10'b01_0000_0000 || o_dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_scan got=%b/%b exp=%b/%b", obs(), o_dbg_state, 10'b01_0000_0000, 3'd0);
        end
        @(negedge i_clk);
        checks++;
        if (o_tick !== 4'b0000 || o_level !== 4'b0000) begin
            errors++;
            $display("FAIL no_residual_tick got=%b/%b exp=0000/0000", o_tick, o_level);
        end
    endtask

    task automatic test_level();
        logic [9:0] ev;
        int toggles;
        int exp_toggles;
        logic prev;
        toggles = 0;
        apply_reset();
        prev = 1'b0;
        for (int c = 0; c < 70; c++) begin
            step(ev);
            checks++;
            if (obs() !== ev) begin
                errors++;
                $display("FAIL level cyc=%0d got=%b exp=%b", m_cyc, obs(), ev);
            end
            if (o_level[0] !== prev) toggles++;
            prev = o_level[0];
            if (m_cyc == 1) set_cfg(1, 0, 1, 2);
            else            set_cfg(0, 0, 0, 0);
            model_commit();
        end
`ifdef CLK_TICK_SCHED_LEVEL_EN
        exp_toggles = 3;
`else
        exp_toggles = 0;
`endif
        checks++;
        if (toggles != exp_toggles) begin
            errors++;
            $display("FAIL level_toggles got=%0d exp=%0d", toggles, exp_toggles);
        end
    endtask

    task automatic test_random();
        logic [9:0] ev;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            step(ev);
            checks++;
            if (obs() !== ev) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b exp=%b", m_cyc, obs(), ev);
            end
            checks++;
            if ($countones(o_tick) > 1) begin
                errors++;
                $display("FAIL tick_onehot cyc=%0d got=%b exp=at most one bit", m_cyc, o_tick);
            end
            if ($urandom_range(0, 3) == 0)
                set_cfg(1, $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 5));
            else
                set_cfg(0, 0, 0, 0);
            model_commit();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_periods();
        test_back_to_back();
        test_disable();
        test_coincident_reset();
        test_level();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Time limit
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "time limit");
    end

endmodule
